perf_dump_ctrl: RTL and testbench

Central performance-counter controller for the debug infrastructure. Counts up to EVENT_NUM per-cycle event pulses in saturating counters and keeps the global cycle count. It also drives the log-enable window. Periodically, or on request, it snapshots every counter and serialises the snapshot over a single valid/ready port, so many event sources can share one log/export channel instead of each instantiating its own logger.

---
 rtl/perf_dump_ctrl.sv | 151 +++++++++++++++
 tb/tb_perf_dump_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_dump_ctrl.sv
// perf_dump_ctrl: saturating per-event counters plus a cycle counter, dumped as snapshots over one valid/ready stream
//   clk          clock
//   rst          synchronous reset, active-low
//   event_i      per-cycle event pulses, one bit per counter
//   clear_i      zero the live counters and the period timer
//   dump_req_i   request an immediate dump
//   cycle_cnt_o  free-running 64-bit cycle count
//   log_valid_o  registered log window enable
//   out_valid_o, out_ready_i, out_id_o, out_count_o, out_cycle_o
//                snapshot stream: one entry per event index, all sharing the snapshot cycle
//   busy_o       a dump is being sent or is queued
//   overrun_o    sticky: a trigger arrived while one was already queued
module perf_dump_ctrl #(
    parameter int EVENT_NUM   = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int DUMP_PERIOD = 4096,
    parameter int LOG_START   = 0,
    parameter int LOG_END     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [EVENT_NUM-1:0]         event_i,
    input  logic                         clear_i,
    input  logic                         dump_req_i,
    output logic [63:0]                  cycle_cnt_o,
    output logic                         log_valid_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [$clog2(EVENT_NUM)-1:0] out_id_o,
    output logic [CNT_WIDTH-1:0]         out_count_o,
    output logic [63:0]                  out_cycle_o,
    output logic                         busy_o,
    output logic                         overrun_o
);
    localparam int IDW = $clog2(EVENT_NUM);
    localparam logic [IDW-1:0] LAST_ID = IDW'(EVENT_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [31:0] PER_LAST = 32'(DUMP_PERIOD - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;
    logic [IDW-1:0]        idx_q, idx_d;
    logic [63:0]           cycle_q, cycle_d;
    logic [63:0]           out_cycle_q, out_cycle_d;
    logic                  log_q, log_d;
    logic [31:0]           timer_q, timer_d;
    logic [CNT_WIDTH-1:0]  live_q [EVENT_NUM];
    logic [CNT_WIDTH-1:0]  live_d [EVENT_NUM];
    logic [CNT_WIDTH-1:0]  shadow_q [EVENT_NUM];
    logic [CNT_WIDTH-1:0]  shadow_d [EVENT_NUM];
    logic [CNT_WIDTH-1:0]  bumped [EVENT_NUM];
    logic                  per_trig, trig, take;
    logic signed [64:0]    cyc_s;

    assign cycle_d = cycle_q + 64'd1;

    // Window is evaluated on the next count so log_valid_o lines up with cycle_cnt_o.
    assign cyc_s = $signed({1'b0, cycle_d});
    assign log_d = (cyc_s >= $signed(65'(LOG_START))) && (LOG_END == 0 || cyc_s < $signed(65'(LOG_END)));

    assign per_trig = (DUMP_PERIOD != 0) && (timer_q == PER_LAST);
    assign trig     = per_trig || dump_req_i;
    assign timer_d  = (DUMP_PERIOD == 0 || clear_i || per_trig) ? 32'd0 : timer_q + 32'd1;

    // Live value plus this cycle's event, saturated; feeds both the live update and the snapshot.
    always_comb begin
        for (int i = 0; i < EVENT_NUM; i++)
            bumped[i] = (event_i[i] && live_q[i] != CNT_MAX) ? live_q[i] + CNT_WIDTH'(1) : live_q[i];
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        idx_d       = idx_q;
        out_cycle_d = out_cycle_q;
        shadow_d    = shadow_q;
        take        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig || pend_q) begin
                    take        = 1'b1;
                    shadow_d    = bumped;
                    out_cycle_d = cycle_q;
                    idx_d       = '0;
                    pend_d      = 1'b0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (trig) begin
                    if (pend_q)
                        ovr_d = 1'b1;
                    else
                        pend_d = 1'b1;
                end
                if (out_ready_i) begin
                    if (idx_q == LAST_ID)
                        state_d = S_IDLE;
                    else
                        idx_d = idx_q + IDW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A snapshot moves the counts into the shadows, so the live window restarts from zero.
    always_comb begin
        for (int i = 0; i < EVENT_NUM; i++)
            live_d[i] = (take || clear_i) ? '0 : bumped[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            idx_q       <= '0;
            cycle_q     <= '0;
            out_cycle_q <= '0;
            log_q       <= 1'b0;
            timer_q     <= '0;
            live_q      <= '{default: '0};
            shadow_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            idx_q       <= idx_d;
            cycle_q     <= cycle_d;
            out_cycle_q <= out_cycle_d;
            log_q       <= log_d;
            timer_q     <= timer_d;
            live_q      <= live_d;
            shadow_q    <= shadow_d;
        end
    end

    assign cycle_cnt_o = cycle_q;
    assign log_valid_o = log_q;
    assign out_valid_o = (state_q == S_SEND);
    assign out_id_o    = idx_q;
    assign out_count_o = shadow_q[idx_q];
    assign out_cycle_o = out_cycle_q;
    assign busy_o      = (state_q == S_SEND) || pend_q;
    assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_perf_dump_ctrl.sv
// tb_perf_dump_ctrl: two configurations checked every cycle against a snapshot-list model plus literal expectations
module tb_perf_dump_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] ev;
    logic clr, req, rdy;
    logic [63:0] d_cyc [2];
    logic [63:0] d_ocyc [2];
    logic d_log [2];
    logic d_val [2];
    logic d_busy [2];
    logic d_ovr [2];
    logic [2:0] d_id [2];
    logic [7:0] cnt_a;
    logic [3:0] cnt_b;

    int n_pass = 0;
    int n_tot = 0;

    int per_v [2] = '{16, 0};
    int max_v [2] = '{255, 15};
    longint unsigned ls_v [2] = '{10, 0};
    longint unsigned le_v [2] = '{20, 0};

    logic [63:0] m_cyc [2];
    logic [63:0] m_ecyc [2];
    bit m_log [2];
    bit m_act [2];
    bit m_pend [2];
    bit m_ovr [2];
    int m_head [2];
    int m_tmr [2];
    int m_live [2][N];
    int m_ent [2][N];

    int seen_id [N];
    int seen_cnt [N];
    int cap [N];
    int n_hs, n_cap;
    logic [17:0] vec;
    bit found, stale;

    always #5 clk = ~clk;

    perf_dump_ctrl #(.EVENT_NUM(N), .CNT_WIDTH(8), .DUMP_PERIOD(16), .LOG_START(10), .LOG_END(20)) u_a (
        .clk(clk), .rst(rst), .event_i(ev), .clear_i(clr), .dump_req_i(req),
        .cycle_cnt_o(d_cyc[0]), .log_valid_o(d_log[0]), .out_valid_o(d_val[0]), .out_ready_i(rdy),
        .out_id_o(d_id[0]), .out_count_o(cnt_a), .out_cycle_o(d_ocyc[0]), .busy_o(d_busy[0]), .overrun_o(d_ovr[0])
    );

    perf_dump_ctrl #(.EVENT_NUM(N), .CNT_WIDTH(4), .DUMP_PERIOD(0), .LOG_START(0), .LOG_END(0)) u_b (
        .clk(clk), .rst(rst), .event_i(ev), .clear_i(clr), .dump_req_i(req),
        .cycle_cnt_o(d_cyc[1]), .log_valid_o(d_log[1]), .out_valid_o(d_val[1]), .out_ready_i(rdy),
        .out_id_o(d_id[1]), .out_count_o(cnt_b), .out_cycle_o(d_ocyc[1]), .busy_o(d_busy[1]), .overrun_o(d_ovr[1])
    );

    function automatic logic [63:0] cnt(int k);
        return (k == 1) ? 64'(cnt_b) : 64'(cnt_a);
    endfunction

    task automatic chk(string nm, int k, logic [63:0] got, logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, k, $time, got, exp);
    endtask

    // One clock of the model: triggers queue a whole snapshot of N entries that drain on handshakes.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_cyc[k] = '0; m_ecyc[k] = '0; m_log[k] = 0; m_act[k] = 0;
                m_pend[k] = 0; m_ovr[k] = 0; m_head[k] = 0; m_tmr[k] = 0;
                for (int i = 0; i < N; i++) begin
                    m_live[k][i] = 0;
                    m_ent[k][i] = 0;
                end
            end else begin
                bit ptrig, trig, take;
                ptrig = (per_v[k] != 0) && (m_tmr[k] == per_v[k] - 1);
                trig = ptrig || req;
                take = !m_act[k] && (trig || m_pend[k]);
                if (m_act[k]) begin
                    if (trig) begin
                        if (m_pend[k]) m_ovr[k] = 1;
                        else m_pend[k] = 1;
                    end
                    if (rdy) begin
                        m_head[k]++;
                        if (m_head[k] == N) m_act[k] = 0;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    int nxt;
                    nxt = ev[i] ? m_live[k][i] + 1 : m_live[k][i];
                    if (nxt > max_v[k]) nxt = max_v[k];
                    if (take) m_ent[k][i] = nxt;
                    m_live[k][i] = (take || clr) ? 0 : nxt;
                end
                if (take) begin
                    m_act[k] = 1; m_head[k] = 0; m_pend[k] = 0; m_ecyc[k] = m_cyc[k];
                end
                m_tmr[k] = (per_v[k] == 0 || clr || ptrig) ? 0 : m_tmr[k] + 1;
                m_cyc[k] = m_cyc[k] + 64'd1;
                m_log[k] = (m_cyc[k] >= ls_v[k]) && (le_v[k] == 0 || m_cyc[k] < le_v[k]);
            end
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            chk("cycle_cnt", k, d_cyc[k], m_cyc[k]);
            chk("log_valid", k, 64'(d_log[k]), 64'(m_log[k]));
            chk("out_valid", k, 64'(d_val[k]), 64'(m_act[k]));
            chk("busy", k, 64'(d_busy[k]), 64'(m_act[k] || m_pend[k]));
            chk("overrun", k, 64'(d_ovr[k]), 64'(m_ovr[k]));
            if (m_act[k]) begin
                chk("out_id", k, 64'(d_id[k]), 64'(m_head[k]));
                chk("out_count", k, cnt(k), 64'(m_ent[k][m_head[k]]));
                chk("out_cycle", k, d_ocyc[k], m_ecyc[k]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        @(negedge clk);
        compare();
    endtask

    task automatic obs();
        if (d_val[1] && rdy) begin
            cap[d_id[1]] = int'(cnt(1));
            n_cap++;
        end
        tick();
    endtask

    initial begin
        rst = 0; ev = '0; clr = 0; req = 0; rdy = 1;
        repeat (3) tick();
        chk("rst_cyc", 0, d_cyc[0], 64'd0);
        chk("rst_valid", 1, 64'(d_val[1]), 64'd0);
        chk("rst_busy", 0, 64'(d_busy[0]), 64'd0);
        rst = 1; ev = 8'h04;
        repeat (5) tick();
        chk("cyc_after5", 0, d_cyc[0], 64'd5);
        repeat (4) tick();
        chk("log_at9", 0, 64'(d_log[0]), 64'd0);
        tick();
        chk("log_at10", 0, 64'(d_log[0]), 64'd1);
        repeat (8) tick();
        chk("per1_id", 0, 64'(d_id[0]), 64'd2);
        chk("per1_cnt", 0, cnt(0), 64'd16);
        chk("per1_cyc", 0, d_ocyc[0], 64'd15);
        tick();
        chk("log_at19", 0, 64'(d_log[0]), 64'd1);
        tick();
        chk("log_at20", 0, 64'(d_log[0]), 64'd0);
        repeat (14) tick();
        chk("per2_id", 0, 64'(d_id[0]), 64'd2);
        chk("per2_cnt", 0, cnt(0), 64'd16);
        chk("per2_cyc", 0, d_ocyc[0], 64'd31);

        ev = 8'ha5; req = 1; n_hs = 0;
        for (int j = 0; j < 40; j++) begin
            rdy = (j % 4 == 0) || (j % 4 == 3);
            if (d_val[1] && rdy) begin
                if (n_hs < N) begin
                    seen_id[n_hs] = int'(d_id[1]);
                    seen_cnt[d_id[1]] = int'(cnt(1));
                end
                n_hs++;
            end
            tick();
            req = 0;
        end
        rdy = 1;
        chk("bp_entries", 1, 64'(n_hs), 64'd8);
        for (int i = 0; i < N; i++) chk("bp_order", 1, 64'(seen_id[i]), 64'(i));
        chk("bp_sat_id2", 1, 64'(seen_cnt[2]), 64'd15);
        chk("bp_id0", 1, 64'(seen_cnt[0]), 64'd1);
        chk("bp_id1", 1, 64'(seen_cnt[1]), 64'd0);

        ev = 8'h11; vec = '0; req = 1;
        for (int j = 1; j <= 18; j++) begin
            tick();
            req = (j >= 2 && j <= 4);
            vec = {vec[16:0], d_val[1]};
        end
        req = 0;
        chk("pend_valid_seq", 1, 64'(vec), 64'(18'b11111111_0_11111111_0));
        chk("pend_overrun", 1, 64'(d_ovr[1]), 64'd1);

        ev = '0; clr = 1;
        tick();
        clr = 0; ev = 8'h01;
        repeat (20) tick();
        ev = 8'h03; req = 1; clr = 1; n_cap = 0;
        obs();
        req = 0; clr = 0; ev = 8'h01;
        repeat (3) obs();
        ev = '0;
        repeat (12) obs();
        chk("sat_entries", 1, 64'(n_cap), 64'd8);
        chk("sat_id0", 1, 64'(cap[0]), 64'd15);
        chk("clr_id1", 1, 64'(cap[1]), 64'd1);
        chk("clr_id2", 1, 64'(cap[2]), 64'd0);
        n_cap = 0; req = 1;
        obs();
        req = 0;
        repeat (12) obs();
        chk("post_entries", 1, 64'(n_cap), 64'd8);
        chk("post_id0", 1, 64'(cap[0]), 64'd3);
        chk("post_id1", 1, 64'(cap[1]), 64'd0);
        chk("overrun_sticky", 1, 64'(d_ovr[1]), 64'd1);

        req = 1; found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            tick();
            req = 0;
            if (d_val[1] && d_id[1] == 3'd3) found = 1;
        end
        chk("reach_id3", 1, 64'(found), 64'd1);
        rst = 0;
        repeat (2) tick();
        rst = 1;
        tick();
        chk("mid_rst_valid", 1, 64'(d_val[1]), 64'd0);
        chk("mid_rst_busy", 1, 64'(d_busy[1]), 64'd0);
        chk("mid_rst_ovr", 1, 64'(d_ovr[1]), 64'd0);
        chk("mid_rst_cyc", 1, d_cyc[1], 64'd1);
        chk("mid_rst_cnt", 1, cnt(1), 64'd0);
        stale = 0;
        repeat (10) begin
            tick();
            if (d_val[1]) stale = 1;
        end
        chk("no_stale", 1, 64'(stale), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
